addsub_serial: RTL and testbench

Parametrised digit-serial add/subtract unit. It is the WIDTH-generic successor of the 4-bit ripple add/sub and processes CHUNK bits per clock, from LSB to MSB. Operands enter through a valid/ready handshake. The result and the C/V/Z/N flags are returned through a second valid/ready handshake. It sits in the ALU datapath wherever wide operands are needed and a full-width carry chain is too slow or too large.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_chunk.sv | 21 ++
 rtl/addsub_serial.sv | 132 +++++++++++++
 tb/tb_addsub_serial.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - FSM encoding, mode constants and saturation helper for addsub_serial
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    localparam int SAT_MAX_W = 64;

    // Most positive (sign=0) or most negative (sign=1) value of a width-bit
    // two's-complement number, right-aligned in a SAT_MAX_W-bit word.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic sign);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (width - 1);
        return sign ? msb : (msb - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - CHUNK-bit ripple adder slice with carry-out and carry-into-MSB
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // The carry into the top bit is recovered from that bit's own sum.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial add/sub, CHUNK bits per cycle; ADDSUB_SAT_EN enables saturation
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t state, state_next;

    logic [WIDTH-1:0]       a_reg, b_reg, s_reg, s_final;
    logic [WIDTH+CHUNK-1:0] s_cat;
    logic [IW-1:0]          idx;
    logic                   carry, c_reg, v_reg;
    logic [CHUNK-1:0]       sum_chunk;
    logic                   cout, cmsb;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_reg[CHUNK-1:0]),
        .b    (b_reg[CHUNK-1:0]),
        .cin  (carry),
        .sum  (sum_chunk),
        .cout (cout),
        .cmsb (cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = ST_RUN;
            ST_RUN:  if (idx == LAST) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands shift right one chunk per RUN cycle; sum chunks enter s from the top,
    // so after NCHUNK cycles the first chunk has reached bit 0.
    assign s_cat = {sum_chunk, s_reg};

`ifdef ADDSUB_SAT_EN
    logic a_sign;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            c_reg <= 1'b0;
            v_reg <= 1'b0;
`ifdef ADDSUB_SAT_EN
            a_sign <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= (m == MODE_ADD) ? b : ~b;
                    carry <= (m == MODE_SUB);
                    idx   <= '0;
                    c_reg <= 1'b0;
                    v_reg <= 1'b0;
`ifdef ADDSUB_SAT_EN
                    a_sign <= a[WIDTH-1];
`endif
                end
                ST_RUN: begin
                    a_reg <= a_reg >> CHUNK;
                    b_reg <= b_reg >> CHUNK;
                    s_reg <= s_cat[WIDTH+CHUNK-1:CHUNK];
                    carry <= cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        c_reg <= cout;
                        v_reg <= cout ^ cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDSUB_SAT_EN
    assign s_final = v_reg ? WIDTH'(sat_value(WIDTH, a_sign)) : s_reg;
`else
    assign s_final = s_reg;
`endif

    assign s = s_final;
    assign c = c_reg;
    assign v = v_reg;
    assign z = out_valid & ~|s_final;
    assign n = out_valid & s_final[WIDTH-1];

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - scoreboard bench for addsub_serial (WIDTH=16, CHUNK=4)
`timescale 1ns/1ps
module tb_addsub_serial;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, m, out_ready;
    logic        in_ready, out_valid, c, v, z, n;
    logic [15:0] a, b, s;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t expq[$];
    int   accq[$];
    bit   seen_cur    = 1'b0;
    bit   rand_ready  = 1'b0;
    bit   force_ready = 1'b1;

    addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c),
        .v         (v),
        .z         (z),
        .n         (n)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic md);
        exp_t        e;
        int unsigned ux, uy, r_u;
        int          sx, sy, r_s;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (md) begin
            r_u = ux + uy;
            r_s = sx + sy;
            e.c = (r_u > 32'hFFFF);
        end else begin
            r_u = ux - uy;
            r_s = sx - sy;
            e.c = (ux >= uy);
        end
        e.s = r_u[15:0];
        e.v = (r_s > 32767) || (r_s < -32768);
`ifdef ADDSUB_SAT_EN
        if (e.v) e.s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        e.z = (e.s == 16'h0000);
        e.n = e.s[15];
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end

    // Monitor: compares every DONE cycle against the scoreboard head, pops on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                chk("stale_out_valid", 32'd1, 32'd0);
            end else begin
                if (!seen_cur) begin
                    chk("latency", cyc - accq[0], NCHUNK);
                    seen_cur = 1'b1;
                end
                chk("s", s, expq[0].s);
                chk("cvzn", {c, v, z, n}, {expq[0].c, expq[0].v, expq[0].z, expq[0].n});
                chk("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    void'(expq.pop_front());
                    void'(accq.pop_front());
                    seen_cur = 1'b0;
                end
            end
        end
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm,
                         input bit expect_it, output int acc);
        bit r;
        bit ok;
        ok  = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        m = tm;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) ok = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc;
            chk("in_ready_after_accept", in_ready, 0);
            if (expect_it) begin
                expq.push_back(model(ta, tb_v, tm));
                accq.push_back(acc);
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!out_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (!out_valid) chk(name, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (expq.size() != 0 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk(name, expq.size(), 0);
    endtask

    initial begin
        int          acc;
        int          k;
        logic [15:0] ra, rb;
        logic [15:0] corner [4];
        corner[0] = 16'h7FFF;
        corner[1] = 16'h8000;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h0000;

        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        m = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_cvzn", {c, v, z, n}, 0);
        rst = 1'b0;
        in_valid = 1'b0;

        do_op(16'h1234, 16'h0FF1, 1'b1, 1'b1, acc);
        drain("drain_t1");

        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, acc);
        do_op(16'h1234, 16'h1234, 1'b0, 1'b1, acc);
        drain("drain_t2");

        do_op(16'h7FFF, 16'h0001, 1'b1, 1'b1, acc);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, acc);
        drain("drain_t34");

        force_ready = 1'b0;
        do_op(16'hA5A5, 16'h1234, 1'b0, 1'b1, acc);
        wait_valid("t5_out_valid_timeout");
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            m = 1'($urandom);
            @(negedge clk);
            chk("t5_in_ready_hold", in_ready, 0);
        end
        @(posedge clk);
        #1;
        k = cyc;
        force_ready = 1'b1;
        do_op(16'h0102, 16'h0304, 1'b1, 1'b1, acc);
        chk("t5_accept_edge", acc, k + 2);
        drain("drain_t5");

        do_op(16'h00FF, 16'h0F0F, 1'b1, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_s", s, 0);
        repeat (8) @(posedge clk);
        #1;
        do_op(16'h0001, 16'h0001, 1'b1, 1'b1, acc);
        drain("drain_t6");

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            do_op(ra, rb, 1'($urandom), 1'b1, acc);
        end
        drain("drain_random");
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
